grf: RTL
========

# grf

General register file for the single-cycle MIPS datapath: 32 × 32-bit registers, two combinational read ports and one synchronous write port. The write address (A3) comes directly from the 5-bit write-register selector. That selector picks rt, rd or $ra (31) under control of the decoder. Also emits a registered one-cycle write-back trace record, and a commit counter, for the testbench and log comparison.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (depth = 2^ADDR_W)
- BYPASS, 1, 1 = a read of the register being written this cycle returns WD; 0 = returns old value

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- we  in  1  write enable (RegWrite)
- a1  in  ADDR_W  read address port 1 (rs)
- a2  in  ADDR_W  read address port 2 (rt)
- a3  in  ADDR_W  write address, from write-register selector
- wd  in  DATA_W  write data
- pc  in  32  PC of the instruction currently writing; trace only
- rd1  out  DATA_W  read data 1, combinational
- rd2  out  DATA_W  read data 2, combinational
- wb_valid  out  1  trace: a write committed on the previous edge
- wb_pc  out  32  trace: PC of committed write
- wb_addr  out  ADDR_W  trace: register written
- wb_data  out  DATA_W  trace: value written
- wb_count  out  32  number of committed writes since reset

## Operation
- Storage: regs[1..31], DATA_W each. Register 0 is not stored.
- Register 0:
  - reads of index 0 return 0 on both ports, regardless of BYPASS.
  - writes to index 0 are discarded, and are not committed (no trace, no count).
- Commit condition:
  - commit = we && (a3 != 0) && !reset.
  - On the rising edge with commit set, regs[a3] <= wd.
- Reads:
  - rdN = 0 if aN == 0.
  - Otherwise, if BYPASS && commit && aN == a3, rdN = wd.
  - Otherwise rdN = regs[aN].
  - a1 == a2 is legal; both ports return the same value.
- Trace, registered on each edge:
  - wb_valid <= commit.
  - When commit is set, wb_pc <= pc, wb_addr <= a3, wb_data <= wd.
  - Otherwise wb_pc, wb_addr and wb_data hold their previous values.
- Counter: on commit, wb_count <= wb_count + 1, mod 2^32. Wraps from 0xFFFF_FFFF to 0 silently.
- Reset, on an edge with reset = 1:
  - all regs <= 0; wb_valid, wb_pc, wb_addr, wb_data, wb_count <= 0.
  - Reset has priority over a simultaneous we. The write is lost and not traced.
- Reset mid-run: one reset edge fully clears state. The first write after reset is counted as 1.
- X-safety: when we == 0, a3 and wd may be X. State, trace outputs and counter must not change.

## Timing
- Read latency: 0 cycles, combinational from aN and register state (plus wd/a3/we when BYPASS = 1).
- Write latency:
  - the new value is visible at rdN (unbypassed) immediately after the committing edge.
  - with BYPASS = 1 it is visible in the same cycle.
- Trace latency: wb_* reflect the write committed at the most recent edge. wb_valid stays high for exactly one cycle per commit.
- Back-to-back writes to the same register: the last one wins. Each is traced and counted separately.
- Values after reset: rd1 = rd2 = 0 for all addresses; all wb_* = 0.

## Structure
- Shared package/header holds:
  - REG_ZERO = 5'd0, REG_RA = 5'd31 (also used by the write-register selector and its control encoding).
  - DATA_W and ADDR_W defaults.
- One sub-module, grf_trace:
  - inputs: commit, pc, a3, wd.
  - holds the wb_* registers and wb_count.
  - keeps trace logic removable without touching the storage array.
- Storage array, read muxing and bypass stay in grf.

## Test plan
- Reset then read: assert reset one cycle. Sweep a1/a2 over 0..31 → rd1 = rd2 = 0; wb_count = 0, wb_valid = 0.
- Basic write/read:
  - stimulus: we = 1, a3 = 5, wd = 0x1234_5678, pc = 0x3000.
  - next cycle, a1 = 5 → rd1 = 0x1234_5678.
  - wb_valid = 1, wb_pc = 0x3000, wb_addr = 5, wb_data = 0x1234_5678, wb_count = 1.
  - one cycle later wb_valid = 0.
- $0 protection: we = 1, a3 = 0, wd = 0xFFFF_FFFF → rd1(a1 = 0) = 0, wb_valid stays 0, wb_count unchanged.
- Bypass:
  - stimulus: BYPASS = 1; we = 1, a3 = a1 = a2 = 31, wd = 0x0000_3008.
  - required: rd1 = rd2 = 0x0000_3008 in the same cycle.
  - with BYPASS = 0: old value in the same cycle, new value next cycle.
- Reset priority:
  - stimulus: write 7 → r9; then reset = 1 together with we = 1, a3 = 9, wd = 0xAA.
  - required: r9 = 0, wb_count = 0, no trace.
- Counter wrap: force wb_count to 0xFFFF_FFFF (hierarchical deposit), commit one write → wb_count = 0, wb_valid = 1.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared constants for the general register file and the write-register selector.
package grf_pkg;
   localparam int GRF_DATA_W = 32;
   localparam int GRF_ADDR_W = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // Decoder control for the write-register selector feeding a3.
   typedef enum logic [1:0] {
      WSEL_RT = 2'd0,
      WSEL_RD = 2'd1,
      WSEL_RA = 2'd2
   } wsel_e;

   function automatic logic [4:0] wsel_addr(input wsel_e sel, input logic [4:0] rt,
                                            input logic [4:0] rd);
      case (sel)
         WSEL_RT: wsel_addr = rt;
         WSEL_RD: wsel_addr = rd;
         default: wsel_addr = REG_RA;
      endcase
   endfunction
endpackage

// File: rtl/grf_trace.sv
// Registered write-back trace record and commit counter; independent of the storage array.
module grf_trace
   import grf_pkg::*;
#(
   parameter int DATA_W = GRF_DATA_W,
   parameter int ADDR_W = GRF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              commit,
   input  logic [31:0]       pc,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd,
   output logic              wb_valid,
   output logic [31:0]       wb_pc,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       wb_count
);
   logic              wb_valid_q;
   logic [31:0]       wb_pc_q, wb_count_q, wb_count_d;
   logic [ADDR_W-1:0] wb_addr_q;
   logic [DATA_W-1:0] wb_data_q;

   // Plain 32-bit add wraps silently at 2^32.
   assign wb_count_d = commit ? wb_count_q + 32'd1 : wb_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid_q <= 1'b0;
         wb_pc_q    <= '0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         wb_count_q <= '0;
      end else begin
         wb_valid_q <= commit;
         wb_count_q <= wb_count_d;
         if (commit) begin
            wb_pc_q   <= pc;
            wb_addr_q <= a3;
            wb_data_q <= wd;
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_pc    = wb_pc_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;
   assign wb_count = wb_count_q;
endmodule

// File: rtl/grf.sv
// MIPS general register file: 2 combinational read ports, 1 synchronous write port, $0 hardwired.
module grf
   import grf_pkg::*;
#(
   parameter int DATA_W = GRF_DATA_W,
   parameter int ADDR_W = GRF_ADDR_W,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd,
   input  logic [31:0]       pc,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              wb_valid,
   output logic [31:0]       wb_pc,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       wb_count
);
   localparam int NREG = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regs_q [1:NREG-1];
   logic              commit;

   // we gates everything first so an undriven a3/wd cannot disturb state when idle.
   assign commit = we && (a3 != ZERO) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
      end else if (commit) begin
         regs_q[a3] <= wd;
      end
   end

   always_comb begin
      rd1 = '0;
      if (a1 != ZERO) begin
         if (BYPASS && commit && (a1 == a3)) rd1 = wd;
         else                                rd1 = regs_q[a1];
      end
   end

   always_comb begin
      rd2 = '0;
      if (a2 != ZERO) begin
         if (BYPASS && commit && (a2 == a3)) rd2 = wd;
         else                                rd2 = regs_q[a2];
      end
   end

   grf_trace #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_trace (
      .clk      (clk),
      .reset    (reset),
      .commit   (commit),
      .pc       (pc),
      .a3       (a3),
      .wd       (wd),
      .wb_valid (wb_valid),
      .wb_pc    (wb_pc),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .wb_count (wb_count)
   );
endmodule
